packet_loader: RTL

PACKET_LOADER -- requirements
Module: packet_loader

---
 rtl/loader_pkg.sv | 15 +
 rtl/watchdog_timer.sv | 45 ++++
 rtl/packet_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and default sizing for the packet loader and its watchdog.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_e;

  localparam int DEF_WORD_SIZE      = 16;
  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/watchdog_timer.sv
// Inter-word watchdog: counts enabled clocks since the last clear and
// flags the cycle whose closing edge would make the count reach the limit.
// A clear in that same cycle wins, so a word arriving on the last allowed
// cycle is never reported as a timeout.
module watchdog_timer
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: held at zero when disabled or cleared, restarts after expiry.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (!enable || clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      expired = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/packet_loader.sv
// Packet loader: parses address / length / payload / checksum words from a
// receiver and writes the payload into memory at consecutive addresses.
// All outputs come straight from flops.
module packet_loader
  import loader_pkg::*;
#(
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [WORD_SIZE-1:0]  word_in,
  input  logic                  word_valid_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [WORD_SIZE-1:0]  wr_data_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);

  // Remaining-count width must hold 2^ADDR_WIDTH itself; the length compare
  // is done one bit wider than either operand so nothing is truncated.
  localparam int RW = ADDR_WIDTH + 1;
  localparam int LW = ((WORD_SIZE > RW) ? WORD_SIZE : RW) + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(1) << ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [WORD_SIZE-1:0]    sum_q, sum_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_SIZE-1:0]    wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [LW-1:0]           len_ext;
  logic                    len_ok;
  logic                    wd_enable;
  logic                    wd_expired;

  assign len_ext   = LW'(word_in);
  assign len_ok    = (len_ext != '0) && (len_ext <= MAX_LEN);
  assign wd_enable = (state_q != ST_IDLE);

  watchdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .clear  (word_valid_in),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Packet parser: next state, write strobe and status pulses.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (word_valid_in) begin
          addr_d  = ADDR_WIDTH'(word_in);
          sum_d   = word_in;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (word_valid_in) begin
          if (len_ok) begin
            rem_d   = RW'(word_in);
            sum_d   = sum_q + word_in;
            state_d = ST_DATA;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (word_valid_in) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = word_in;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          sum_d     = sum_q + word_in;
          rem_d     = rem_q - RW'(1);
          if (rem_q == RW'(1)) begin
            state_d = ST_CSUM;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_CSUM: begin
        if (word_valid_in) begin
          if (word_in == sum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers; reset discards any partial packet.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      sum_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign wr_en_out   = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign error_out   = error_q;

endmodule
